// File: rtl/neuron_array_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t (sequencer states), default widths, sat_v saturation helper.
package neuron_array_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_V_W          = 18;
   localparam int DEF_I_W          = 16;
   localparam int DEF_FRAC         = 12;
   localparam int DEF_LEAK_SHIFT   = 4;
   localparam int DEF_REFRAC_STEPS = 8;

   // Clamp a sign-extended value into the signed range of a w-bit word.
   // The result stays 64 bits wide so callers can compare it before truncating.
   function automatic logic signed [63:0] sat_v(input logic signed [63:0] s, input int w);
      logic signed [63:0] vmax;
      logic signed [63:0] vmin;
      vmax = (64'sd1 <<< (w - 1)) - 64'sd1;
      vmin = -vmax - 64'sd1;
      if (s > vmax) begin
         return vmax;
      end else if (s < vmin) begin
         return vmin;
      end
      return s;
   endfunction

endpackage

// File: rtl/neuron_array_lif_core.sv
// Single-channel leaky integrate-and-fire update, purely combinational.
// Latency: 0 cycles (result registered by the caller).
// Backpressure: none; evaluated every cycle, consumed only when the caller writes back.
// Ports: v/r/i current state and input, v_th/v_reset shared constants,
//        v_next/r_next/spike next state and spike flag.
module neuron_lif_core
   import neuron_array_pkg::*;
#(
   parameter int V_W          = DEF_V_W,
   parameter int I_W          = DEF_I_W,
   parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
   parameter int REFRAC_STEPS = DEF_REFRAC_STEPS,
   parameter int R_W          = 4
) (
   input  logic [V_W-1:0] v,
   input  logic [R_W-1:0] r,
   input  logic [I_W-1:0] i,
   input  logic [V_W-1:0] v_th,
   input  logic [V_W-1:0] v_reset,
   output logic [V_W-1:0] v_next,
   output logic [R_W-1:0] r_next,
   output logic           spike
);

   logic signed [V_W-1:0] v_s;
   logic signed [V_W-1:0] leak;
   logic signed [V_W+1:0] v_ext;
   logic signed [V_W+1:0] leak_ext;
   logic signed [V_W+1:0] i_ext;
   logic signed [V_W+1:0] sum;
   logic signed [63:0]    sat64;
   logic signed [63:0]    th64;

   always_comb begin
      v_s      = v;
      leak     = v_s >>> LEAK_SHIFT;
      v_ext    = {{2{v[V_W-1]}}, v};
      leak_ext = {{2{leak[V_W-1]}}, leak};
      i_ext    = {{(V_W+2-I_W){i[I_W-1]}}, i};
      // Two guard bits hold v - leak + i exactly for any operands.
      sum      = v_ext - leak_ext + i_ext;
      sat64    = sat_v({{(62-V_W){sum[V_W+1]}}, sum}, V_W);
      th64     = {{(64-V_W){v_th[V_W-1]}}, v_th};

      v_next = v_reset;
      r_next = r;
      spike  = 1'b0;
      if (r != '0) begin
         // Refractory: clamp membrane, ignore input, count down.
         r_next = r - 1'b1;
      end else if (sat64 >= th64) begin
         spike  = 1'b1;
         r_next = R_W'(REFRAC_STEPS);
      end else begin
         v_next = sat64[V_W-1:0];
      end
   end

endmodule

// File: rtl/neuron_array.sv
// Time-multiplexed array of N_CH LIF neurons sharing one update datapath.
// Latency: step accepted in cycle 0, channel k written at end of cycle k+1, done_o in cycle N_CH+1.
// Backpressure: step_i is a level request sampled only in IDLE; ignored while busy_o is high.
// Ports: emu_clk/emu_rst clock and async reset; step_i request; i_in packed currents;
//        v_th_i/v_reset_i shared threshold and reset value; busy_o/done_o status;
//        v_out packed membranes; spike_o spikes of last completed step.
module neuron_array
   import neuron_array_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int V_W          = DEF_V_W,
   parameter int I_W          = DEF_I_W,
   parameter int FRAC         = DEF_FRAC,
   parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
   parameter int REFRAC_STEPS = DEF_REFRAC_STEPS
) (
   input  logic                emu_clk,
   input  logic                emu_rst,
   input  logic                step_i,
   input  logic [N_CH*I_W-1:0] i_in,
   input  logic [V_W-1:0]      v_th_i,
   input  logic [V_W-1:0]      v_reset_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [N_CH*V_W-1:0] v_out,
   output logic [N_CH-1:0]     spike_o
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int R_W  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

   // FRAC only documents the fixed-point scaling; it must still describe a legal word.
   if (I_W > V_W || FRAC >= V_W) begin : g_bad_cfg
      $error("neuron_array: need I_W <= V_W and FRAC < V_W");
   end

   state_t            state;
   logic [CH_W-1:0]   ch;
   logic [I_W-1:0]    i_sh   [N_CH];
   logic [V_W-1:0]    th_sh;
   logic [V_W-1:0]    vr_sh;
   logic [V_W-1:0]    v_reg  [N_CH];
   logic [R_W-1:0]    r_reg  [N_CH];
   logic [N_CH-1:0]   spk_acc;

   logic [V_W-1:0]    v_nx;
   logic [R_W-1:0]    r_nx;
   logic              spk_nx;

   neuron_lif_core #(
      .V_W          (V_W),
      .I_W          (I_W),
      .LEAK_SHIFT   (LEAK_SHIFT),
      .REFRAC_STEPS (REFRAC_STEPS),
      .R_W          (R_W)
   ) u_core (
      .v       (v_reg[ch]),
      .r       (r_reg[ch]),
      .i       (i_sh[ch]),
      .v_th    (th_sh),
      .v_reset (vr_sh),
      .v_next  (v_nx),
      .r_next  (r_nx),
      .spike   (spk_nx)
   );

   always_ff @(posedge emu_clk or posedge emu_rst) begin
      if (emu_rst) begin
         state   <= IDLE;
         ch      <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         spike_o <= '0;
         spk_acc <= '0;
         th_sh   <= '0;
         vr_sh   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            i_sh[k]  <= '0;
            v_reg[k] <= '0;
            r_reg[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (step_i) begin
                  // Snapshot operands so input changes mid-step cannot leak in.
                  for (int k = 0; k < N_CH; k++) begin
                     i_sh[k] <= i_in[k*I_W +: I_W];
                  end
                  th_sh   <= v_th_i;
                  vr_sh   <= v_reset_i;
                  ch      <= '0;
                  spk_acc <= '0;
                  busy_o  <= 1'b1;
                  state   <= UPDATE;
               end
            end
            UPDATE: begin
               v_reg[ch]   <= v_nx;
               r_reg[ch]   <= r_nx;
               spk_acc[ch] <= spk_nx;
               if (ch == CH_W'(N_CH - 1)) begin
                  ch     <= '0;
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  ch <= ch + 1'b1;
               end
            end
            DONE: begin
               // spike_o publishes the whole step at once and holds until the next one.
               spike_o <= spk_acc;
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_vout
      assign v_out[g*V_W +: V_W] = v_reg[g];
   end

endmodule
